// File: rtl/hworld_obi_mgr.sv
// hworld_obi_mgr: OBI manager that writes operands A and B into the hworld
// register block, then reads back SUM and COUT. One transaction outstanding
// at a time; every address phase is followed by its response phase.
// Optional feature macro: HWORLD_MGR_TIMEOUT_EN adds a per-phase wait timeout
// that aborts the sequence with err_o = 1.
module hworld_obi_mgr #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] sum_o,
  output logic        cout_o,
  output logic        req_o,
  output logic [31:0] addr_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_WA, S_WA_R, S_WB, S_WB_R, S_RS, S_RS_R, S_RC, S_RC_R, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, b_q, sum_q;
  logic        cout_q;
  logic        addr_st, resp_st, adv, abort;

  // Classify the current state as address phase or response phase
  always_comb begin
    addr_st = (state_q == S_WA) || (state_q == S_WB) ||
              (state_q == S_RS) || (state_q == S_RC);
    resp_st = (state_q == S_WA_R) || (state_q == S_WB_R) ||
              (state_q == S_RS_R) || (state_q == S_RC_R);
  end

  // A phase completes on gnt in address states and on rvalid in response states
  assign adv = (addr_st && gnt_i) || (resp_st && rvalid_i);

`ifdef HWORLD_MGR_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  assign abort = (addr_st || resp_st) && !adv && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter restarts whenever the FSM leaves its current state
  always_comb begin
    cnt_d = '0;
    if ((addr_st || resp_st) && !adv && !abort) cnt_d = cnt_q + 32'd1;
  end

  // Error flag is raised by an abort and cleared when a new sequence starts
  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && start_i) err_d = 1'b0;
    else if (abort)                   err_d = 1'b1;
  end

  // Timeout state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q && (state_q == S_DONE);
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: walk the four transactions, or bail out to DONE on abort
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_i)  state_d = S_WA;
        S_WA:    if (gnt_i)    state_d = S_WA_R;
        S_WA_R:  if (rvalid_i) state_d = S_WB;
        S_WB:    if (gnt_i)    state_d = S_WB_R;
        S_WB_R:  if (rvalid_i) state_d = S_RS;
        S_RS:    if (gnt_i)    state_d = S_RS_R;
        S_RS_R:  if (rvalid_i) state_d = S_RC;
        S_RC:    if (gnt_i)    state_d = S_RC_R;
        S_RC_R:  if (rvalid_i) state_d = S_DONE;
        S_DONE:                state_d = S_IDLE;
        default:               state_d = S_IDLE;
      endcase
    end
  end

  // Operands are captured only when a start is accepted, so they stay stable
  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && start_i) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  // Read results update only on the rvalid of their own read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      if (state_q == S_RS_R && rvalid_i) sum_q  <= rdata_i;
      if (state_q == S_RC_R && rvalid_i) cout_q <= rdata_i[0];
    end
  end

  // Bus request signals are decoded from the state so reset drops req_o at once
  always_comb begin
    req_o   = 1'b0;
    addr_o  = '0;
    we_o    = 1'b0;
    wdata_o = '0;
    case (state_q)
      S_WA: begin req_o = 1'b1; addr_o = BASE_ADDR;          we_o = 1'b1; wdata_o = a_q; end
      S_WB: begin req_o = 1'b1; addr_o = BASE_ADDR + 32'h4;  we_o = 1'b1; wdata_o = b_q; end
      S_RS: begin req_o = 1'b1; addr_o = BASE_ADDR + 32'h8;  end
      S_RC: begin req_o = 1'b1; addr_o = BASE_ADDR + 32'hC;  end
      default: ;
    endcase
  end

  assign be_o   = 4'hF;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule
